// File: rtl/alu_control_if.sv
// Bus between the main control unit and the ALU control decoder:
// operation class and function field in, ALU select and illegal flag out.
interface alu_control_if;
   logic [1:0] ALUop;
   logic [5:0] func;
   logic [3:0] ALUctr;
   logic       illegal;

   // Main control side: drives the decode request, observes the result.
   modport master (
      output ALUop,
      output func,
      input  ALUctr,
      input  illegal
   );

   // Decoder side: consumes the request, produces the registered result.
   modport slave (
      input  ALUop,
      input  func,
      output ALUctr,
      output illegal
   );
endinterface

// File: rtl/alu_control.sv
// ALU control decoder for the single-cycle MIPS-subset datapath.
// Combines ALUop with the R-type function field into a 4-bit ALU select,
// flags unsupported function codes, and registers both results.
module alu_control (
   input  logic          clk,
   input  logic          rst,
   alu_control_if.slave  bus
);

   localparam logic [3:0] CTR_AND     = 4'b0000;
   localparam logic [3:0] CTR_OR      = 4'b0001;
   localparam logic [3:0] CTR_ADD     = 4'b0010;
   localparam logic [3:0] CTR_ADDU    = 4'b0011;
   localparam logic [3:0] CTR_SLL     = 4'b0100;
   localparam logic [3:0] CTR_SUB     = 4'b0110;
   localparam logic [3:0] CTR_SUBU    = 4'b0111;
   localparam logic [3:0] CTR_SLT     = 4'b1000;
   localparam logic [3:0] CTR_SLTU    = 4'b1001;
   localparam logic [3:0] CTR_INVALID = 4'b1111;

   logic [3:0] ctr_s;
   logic       illegal_s;
   logic [3:0] ctr_r;
   logic       illegal_r;

   // Decode the current {ALUop, func} into the next ALU select and illegal flag.
   always_comb begin
      ctr_s     = CTR_ADD;
      illegal_s = 1'b0;
      case (bus.ALUop)
         2'b00: begin
            ctr_s = CTR_ADD;
         end
         2'b01, 2'b11: begin
            ctr_s = CTR_SUB;
         end
         2'b10: begin
            case (bus.func)
               6'b100000: ctr_s = CTR_ADD;
               6'b100001: ctr_s = CTR_ADDU;
               6'b100010: ctr_s = CTR_SUB;
               6'b100011: ctr_s = CTR_SUBU;
               6'b100100: ctr_s = CTR_AND;
               6'b100101: ctr_s = CTR_OR;
               6'b000000: ctr_s = CTR_SLL;
               6'b101010: ctr_s = CTR_SLT;
               // Both SLTU encodings seen in the toolchain are accepted.
               6'b101001: ctr_s = CTR_SLTU;
               6'b101011: ctr_s = CTR_SLTU;
               default: begin
                  ctr_s     = CTR_INVALID;
                  illegal_s = 1'b1;
               end
            endcase
         end
         default: begin
            ctr_s     = CTR_ADD;
            illegal_s = 1'b0;
         end
      endcase
   end

   // Output register; reset forces a harmless ADD with no illegal flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctr_r     <= CTR_ADD;
         illegal_r <= 1'b0;
      end else begin
         ctr_r     <= ctr_s;
         illegal_r <= illegal_s;
      end
   end

   assign bus.ALUctr  = ctr_r;
   assign bus.illegal = illegal_r;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed reset/sweep/latency steps
// followed by randomized decodes checked against a table-driven model.
module tb_alu_control;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fails;

   alu_control_if bus ();

   alu_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Supported R-type function codes and the ALU select each one maps to.
   localparam logic [5:0] FUNC_TAB [10] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                            6'b100100, 6'b100101, 6'b000000, 6'b101010,
                                            6'b101001, 6'b101011};
   localparam logic [3:0] CTR_TAB  [10] = '{4'b0010, 4'b0011, 4'b0110, 4'b0111,
                                            4'b0000, 4'b0001, 4'b0100, 4'b1000,
                                            4'b1001, 4'b1001};

   // Reference model: returns {illegal, ALUctr} for one request.
   function automatic logic [4:0] model(input logic [1:0] op, input logic [5:0] f);
      if (op == 2'b00) return {1'b0, 4'b0010};
      if (op != 2'b10) return {1'b0, 4'b0110};
      for (int i = 0; i < 10; i++)
         if (FUNC_TAB[i] == f) return {1'b0, CTR_TAB[i]};
      return {1'b1, 4'b1111};
   endfunction

   task automatic check(input string tag, input logic [3:0] exp_ctr, input logic exp_ill);
      n_checks++;
      assert (bus.ALUctr === exp_ctr) else begin
         n_fails++;
         $error("FAIL %s ALUctr observed=%b expected=%b", tag, bus.ALUctr, exp_ctr);
      end
      n_checks++;
      assert (bus.illegal === exp_ill) else begin
         n_fails++;
         $error("FAIL %s illegal observed=%b expected=%b", tag, bus.illegal, exp_ill);
      end
   endtask

   // Drive a request on the falling edge, then check just after the next rising edge.
   task automatic step(input string tag, input logic [1:0] op, input logic [5:0] f);
      logic [4:0] e;
      @(negedge clk);
      bus.ALUop = op;
      bus.func  = f;
      e = model(op, f);
      @(posedge clk);
      #1;
      check(tag, e[3:0], e[4]);
   endtask

   initial begin
      logic [1:0] op;
      logic [5:0] f;
      n_checks  = 0;
      n_fails   = 0;

      // Reset asserted from time zero: outputs forced before any clock edge.
      rst       = 1'b1;
      bus.ALUop = 2'b10;
      bus.func  = 6'b100010;
      #1;
      check("reset_async", 4'b0010, 1'b0);
      @(posedge clk);
      #1;
      check("reset_held", 4'b0010, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("reset_release", 4'b0110, 1'b0);

      // R-type sweep, one function code per cycle.
      for (int i = 0; i < 10; i++) begin
         step($sformatf("rtype_%b", FUNC_TAB[i]), 2'b10, FUNC_TAB[i]);
         check($sformatf("rtype_tab_%0d", i), CTR_TAB[i], 1'b0);
         if (i == 4) begin
            // Async reset pulse between edges, output currently AND (0000).
            #2;
            rst = 1'b1;
            #1;
            check("midrun_reset", 4'b0010, 1'b0);
            #1;
            rst = 1'b0;
            #1;
            check("midrun_reset_hold", 4'b0010, 1'b0);
         end
      end

      // Non-R-type classes ignore func.
      step("op00", 2'b00, 6'b111111);
      check("op00_const", 4'b0010, 1'b0);
      step("op01", 2'b01, 6'b111111);
      check("op01_const", 4'b0110, 1'b0);
      step("op11", 2'b11, 6'b111111);
      check("op11_const", 4'b0110, 1'b0);

      // Illegal function code, then recovery.
      step("illegal", 2'b10, 6'b111111);
      check("illegal_const", 4'b1111, 1'b1);
      step("after_illegal", 2'b00, 6'b111111);
      check("after_illegal_const", 4'b0010, 1'b0);

      // Latency: mid-cycle input change must not reach the outputs early.
      step("lat_and", 2'b10, 6'b100100);
      #2;
      bus.func = 6'b100101;
      #2;
      check("lat_hold", 4'b0000, 1'b0);
      @(posedge clk);
      #1;
      check("lat_update", 4'b0001, 1'b0);

      // Randomized decodes, half drawn from the supported code table.
      for (int n = 0; n < 300; n++) begin
         op = 2'($urandom_range(3, 0));
         if ($urandom_range(1, 0) == 0)
            f = FUNC_TAB[$urandom_range(9, 0)];
         else
            f = 6'($urandom);
         step($sformatf("rand_%0d_%b_%b", n, op, f), op, f);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
